alu_arbiter: RTL and testbench

- Shares the single 8-bit ALU between two requesters: e.g. the main execute stage (port 0) and the address/branch-compare path (port 1).
- Round-robin arbitration with valid/ready handshakes on request and response sides.
- Drives the ALU operand/opcode inputs from registered state and captures result and flags one cycle later.
- Returns a tagged, cleaned-up response held until the consumer accepts it.

---
 rtl/alu_arbiter_if.sv | 48 ++++
 rtl/alu_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response/ALU bundle for alu_arbiter; slave = arbiter side, master = requesters, consumer and ALU.
interface alu_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int OP_W   = 3
);
   logic              req0_valid;
   logic              req0_ready;
   logic [OP_W-1:0]   req0_aluop;
   logic [DATA_W-1:0] req0_op1;
   logic [DATA_W-1:0] req0_op2;
   logic              req1_valid;
   logic              req1_ready;
   logic [OP_W-1:0]   req1_aluop;
   logic [DATA_W-1:0] req1_op1;
   logic [DATA_W-1:0] req1_op2;
   logic              resp_valid;
   logic              resp_ready;
   logic              resp_id;
   logic [DATA_W-1:0] resp_result;
   logic              resp_equal;
   logic              resp_lessThan;
   logic [DATA_W-1:0] alu_op1;
   logic [DATA_W-1:0] alu_op2;
   logic [OP_W-1:0]   alu_Aluop;
   logic [DATA_W-1:0] alu_result;
   logic              alu_equal;
   logic              alu_lessThan;

   modport slave (
      input  req0_valid, req0_aluop, req0_op1, req0_op2,
      input  req1_valid, req1_aluop, req1_op1, req1_op2,
      output req0_ready, req1_ready,
      output resp_valid, resp_id, resp_result, resp_equal, resp_lessThan,
      input  resp_ready,
      output alu_op1, alu_op2, alu_Aluop,
      input  alu_result, alu_equal, alu_lessThan
   );

   modport master (
      output req0_valid, req0_aluop, req0_op1, req0_op2,
      output req1_valid, req1_aluop, req1_op1, req1_op2,
      input  req0_ready, req1_ready,
      input  resp_valid, resp_id, resp_result, resp_equal, resp_lessThan,
      output resp_ready,
      input  alu_op1, alu_op2, alu_Aluop,
      output alu_result, alu_equal, alu_lessThan
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one 8-bit ALU between two requesters, one op in flight at a time.
// Optional grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
   parameter int DATA_W  = 8,
   parameter int OP_W    = 3,
   parameter int STATS_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   alu_arbiter_if.slave      bus
`ifdef ALU_ARB_STATS_EN
   ,
   input  logic              stats_clr,
   output logic [STATS_W-1:0] grant_cnt0,
   output logic [STATS_W-1:0] grant_cnt1
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   localparam logic [OP_W-1:0] OP_SLT  = OP_W'(5);
   localparam logic [OP_W-1:0] OP_SLTE = OP_W'(6);
   localparam logic [OP_W-1:0] OP_EQ   = OP_W'(7);

   state_t state;
   logic   last_grant;
   logic   sel0, sel1;
   logic   hs0, hs1;

   // Tie goes to the port that did not win last time.
   always_comb begin
      sel0 = bus.req0_valid && (!bus.req1_valid || last_grant);
      sel1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
   end

   // Ready must answer valid in the same cycle, so it is the only combinational output.
   assign bus.req0_ready = (state == IDLE) && sel0 && !reset;
   assign bus.req1_ready = (state == IDLE) && sel1 && !reset;
   assign hs0 = bus.req0_valid && bus.req0_ready;
   assign hs1 = bus.req1_valid && bus.req1_ready;

   // alu_* double as the captured operand registers; they read zero outside EXEC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         last_grant        <= 1'b1;
         bus.alu_op1       <= '0;
         bus.alu_op2       <= '0;
         bus.alu_Aluop     <= '0;
         bus.resp_valid    <= 1'b0;
         bus.resp_id       <= 1'b0;
         bus.resp_result   <= '0;
         bus.resp_equal    <= 1'b0;
         bus.resp_lessThan <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (hs0 || hs1) begin
                  state         <= EXEC;
                  last_grant    <= hs1;
                  bus.alu_op1   <= hs1 ? bus.req1_op1   : bus.req0_op1;
                  bus.alu_op2   <= hs1 ? bus.req1_op2   : bus.req0_op2;
                  bus.alu_Aluop <= hs1 ? bus.req1_aluop : bus.req0_aluop;
               end
            end
            EXEC: begin
               state          <= RESP;
               bus.resp_valid <= 1'b1;
               bus.resp_id    <= last_grant;
               // Compare ops report only their meaningful flags; logic/arith ops report no flags.
               case (bus.alu_Aluop)
                  OP_SLT: begin
                     bus.resp_result   <= '0;
                     bus.resp_equal    <= 1'b0;
                     bus.resp_lessThan <= bus.alu_lessThan;
                  end
                  OP_SLTE: begin
                     bus.resp_result   <= '0;
                     bus.resp_equal    <= bus.alu_equal;
                     bus.resp_lessThan <= bus.alu_lessThan;
                  end
                  OP_EQ: begin
                     bus.resp_result   <= '0;
                     bus.resp_equal    <= bus.alu_equal;
                     bus.resp_lessThan <= 1'b0;
                  end
                  default: begin
                     bus.resp_result   <= bus.alu_result;
                     bus.resp_equal    <= 1'b0;
                     bus.resp_lessThan <= 1'b0;
                  end
               endcase
               bus.alu_op1   <= '0;
               bus.alu_op2   <= '0;
               bus.alu_Aluop <= '0;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  state          <= IDLE;
                  bus.resp_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ALU_ARB_STATS_EN
   // Saturating grant counters; clear wins over a same-cycle grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else if (stats_clr) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else begin
         if (hs0 && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
         if (hs1 && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level reference model checked every cycle, plus directed literal checks.
module tb_alu_arbiter;
   localparam int DATA_W = 8;
   localparam int OP_W   = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_arbiter_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();
`ifdef ALU_ARB_STATS_EN
   logic        stats_clr;
   logic [15:0] gc0, gc1;
`endif

   alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef ALU_ARB_STATS_EN
      ,
      .stats_clr  (stats_clr),
      .grant_cnt0 (gc0),
      .grant_cnt1 (gc1)
`endif
   );

   // ALU stand-in; non-arithmetic ops return junk so result cleaning is observable.
   always_comb begin
      bus.alu_equal    = (bus.alu_op1 == bus.alu_op2);
      bus.alu_lessThan = (bus.alu_op1 <  bus.alu_op2);
      case (bus.alu_Aluop)
         3'd0:    bus.alu_result = bus.alu_op1 & bus.alu_op2;
         3'd1:    bus.alu_result = bus.alu_op1 | bus.alu_op2;
         3'd2:    bus.alu_result = bus.alu_op1 ^ bus.alu_op2;
         3'd3:    bus.alu_result = bus.alu_op1 + bus.alu_op2;
         3'd4:    bus.alu_result = bus.alu_op1 - bus.alu_op2;
         default: bus.alu_result = bus.alu_op1 + bus.alu_op2 + 8'h5A;
      endcase
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // {equal, lessThan, result} the consumer must see for an op on a,b.
   function automatic logic [9:0] clean(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0:    return {2'b00, a & b};
         3'd1:    return {2'b00, a | b};
         3'd2:    return {2'b00, a ^ b};
         3'd3:    return {2'b00, a + b};
         3'd4:    return {2'b00, a - b};
         3'd5:    return {1'b0, a < b, 8'h00};
         3'd6:    return {a == b, a < b, 8'h00};
         default: return {a == b, 1'b0, 8'h00};
      endcase
   endfunction

   // Reference model: at most one outstanding op, issued at cycle m_t.
   int         cyc    = 0;
   bit         m_busy = 0;
   int         m_t    = 0;
   bit         m_id   = 0;
   bit         m_last = 1;
   logic [7:0] m_op1, m_op2;
   logic [2:0] m_op;
   logic [9:0] m_clean;
   bit         v_id = 0;
   logic [9:0] v_clean = '0;
   bit         hs0_q = 0, hs1_q = 0;
   bit         dut_grants[$];

   always @(negedge clk) begin
      bit e_r0, e_r1, e_rv, e_ex;
      cyc++;
      hs0_q = bus.req0_valid && bus.req0_ready;
      hs1_q = bus.req1_valid && bus.req1_ready;
      if (hs0_q) dut_grants.push_back(1'b0);
      if (hs1_q) dut_grants.push_back(1'b1);
      if (reset) begin
         chk("reset_outputs", {bus.req0_ready, bus.req1_ready, bus.resp_valid, bus.resp_id,
             bus.resp_equal, bus.resp_lessThan, bus.resp_result, bus.alu_op1, bus.alu_op2,
             bus.alu_Aluop}, 32'd0);
         m_busy  = 0;
         m_last  = 1;
         v_id    = 0;
         v_clean = '0;
      end else begin
         e_rv = m_busy && (cyc >= m_t + 2);
         e_ex = m_busy && (cyc == m_t + 1);
         e_r0 = !m_busy && bus.req0_valid && (!bus.req1_valid || m_last);
         e_r1 = !m_busy && bus.req1_valid && (!bus.req0_valid || !m_last);
         if (m_busy && cyc == m_t + 2) begin
            v_id    = m_id;
            v_clean = m_clean;
         end
         chk("req_ready", {bus.req0_ready, bus.req1_ready}, {e_r0, e_r1});
         chk("resp_valid", bus.resp_valid, e_rv);
         chk("alu_drive", {bus.alu_op1, bus.alu_op2, bus.alu_Aluop},
             e_ex ? {m_op1, m_op2, m_op} : 19'd0);
         chk("resp_data", {bus.resp_id, bus.resp_equal, bus.resp_lessThan, bus.resp_result},
             {v_id, v_clean});
         if (e_r0 || e_r1) begin
            m_busy  = 1;
            m_t     = cyc;
            m_id    = e_r1;
            m_last  = e_r1;
            m_op1   = e_r1 ? bus.req1_op1   : bus.req0_op1;
            m_op2   = e_r1 ? bus.req1_op2   : bus.req0_op2;
            m_op    = e_r1 ? bus.req1_aluop : bus.req0_aluop;
            m_clean = clean(m_op, m_op1, m_op2);
         end else if (e_rv && bus.resp_ready) begin
            m_busy = 0;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit p, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      if (!p) begin
         bus.req0_valid = 1'b1; bus.req0_aluop = op; bus.req0_op1 = a; bus.req0_op2 = b;
      end else begin
         bus.req1_valid = 1'b1; bus.req1_aluop = op; bus.req1_op1 = a; bus.req1_op2 = b;
      end
   endtask

   task automatic rnd_port(input bit p);
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
      drive(p, 3'($urandom), a, b);
   endtask

   initial begin
      int gl_start;
      reset = 1'b1;
      bus.req0_valid = 0; bus.req0_aluop = 0; bus.req0_op1 = 0; bus.req0_op2 = 0;
      bus.req1_valid = 0; bus.req1_aluop = 0; bus.req1_op1 = 0; bus.req1_op2 = 0;
      bus.resp_ready = 0;
`ifdef ALU_ARB_STATS_EN
      stats_clr = 0;
`endif
      repeat (2) step();
      reset = 1'b0;

      // Single ADD on port 0
      drive(0, 3'd3, 8'h7F, 8'h01);
      @(negedge clk); chk("add_ready0", bus.req0_ready, 1'b1);
      step(); bus.req0_valid = 0;
      @(negedge clk); chk("add_lat_n1", bus.resp_valid, 1'b0);
      step();
      @(negedge clk);
      chk("add_resp", {bus.resp_valid, bus.resp_id, bus.resp_equal, bus.resp_lessThan, bus.resp_result},
          {4'b1000, 8'h80});
      bus.resp_ready = 1;
      step(); bus.resp_ready = 0;

      // EQ on port 1, then SUB on port 0
      drive(1, 3'd7, 8'h55, 8'h55);
      @(negedge clk); chk("eq_ready1", bus.req1_ready, 1'b1);
      step(); bus.req1_valid = 0;
      step();
      @(negedge clk);
      chk("eq_resp", {bus.resp_id, bus.resp_equal, bus.resp_lessThan, bus.resp_result}, {3'b110, 8'h00});
      bus.resp_ready = 1;
      step(); bus.resp_ready = 0;
      drive(0, 3'd4, 8'h03, 8'h05);
      @(negedge clk); chk("sub_ready0", bus.req0_ready, 1'b1);
      step(); bus.req0_valid = 0;
      step();
      @(negedge clk);
      chk("sub_resp", {bus.resp_id, bus.resp_equal, bus.resp_lessThan, bus.resp_result}, {3'b000, 8'hFE});
      bus.resp_ready = 1;
      step(); bus.resp_ready = 0;

      // Backpressure with both requesters waiting
      drive(0, 3'd0, 8'hA5, 8'h3C);
      @(negedge clk); chk("bp_grant", bus.req0_ready, 1'b1);
      step(); bus.req0_valid = 0;
      step();
      drive(0, 3'd1, 8'h11, 8'h22);
      drive(1, 3'd2, 8'h0F, 8'hF0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold", {bus.resp_valid, bus.resp_id, bus.resp_result, bus.req0_ready, bus.req1_ready},
             {2'b10, 8'h24, 2'b00});
         step();
      end
      @(negedge clk); bus.resp_ready = 1;
      step();
      @(negedge clk); chk("bp_regrant", {bus.req0_ready, bus.req1_ready}, 2'b01);
      step(); bus.req1_valid = 0;
      step();
      @(negedge clk); chk("bp_resp1", {bus.resp_id, bus.resp_result}, {1'b1, 8'hFF});
      step();
      @(negedge clk); chk("bp_next0", bus.req0_ready, 1'b1);
      step(); bus.req0_valid = 0;
      step();
      @(negedge clk); chk("bp_resp0", {bus.resp_id, bus.resp_result}, {1'b0, 8'h33});
      step();

      // Reset during EXEC, then a tie must go to port 0
      drive(1, 3'd3, 8'h10, 8'h20);
      step();
      drive(0, 3'd3, 8'h01, 8'h02);
      drive(1, 3'd4, 8'h09, 8'h04);
      reset = 1'b1;
      #1;
      chk("rst_mid", {bus.req0_ready, bus.req1_ready, bus.resp_valid, bus.resp_id, bus.resp_equal,
          bus.resp_lessThan, bus.resp_result, bus.alu_op1, bus.alu_op2, bus.alu_Aluop}, 32'd0);
      gl_start = dut_grants.size();
      step(); reset = 1'b0;
      @(negedge clk); chk("tie_after_reset", {bus.req0_ready, bus.req1_ready}, 2'b10);

      // Fairness: both ports continuously valid
      for (int i = 0; i < 12; i++) begin
         step();
         if (hs0_q) rnd_port(0);
         if (hs1_q) rnd_port(1);
      end
      @(negedge clk);
      chk("fair_count", (dut_grants.size() - gl_start) >= 4, 1'b1);
      if (dut_grants.size() - gl_start >= 4)
         for (int k = 0; k < 4; k++) chk("fair_order", dut_grants[gl_start + k], k % 2);

      // Random traffic with occasional reset pulses
      for (int i = 0; i < 600; i++) begin
         step();
         if (reset) reset = 1'b0;
         else if ($urandom_range(0, 79) == 0) reset = 1'b1;
         if (!bus.req0_valid || hs0_q) begin
            if ($urandom_range(0, 1) != 0) rnd_port(0); else bus.req0_valid = 0;
         end
         if (!bus.req1_valid || hs1_q) begin
            if ($urandom_range(0, 1) != 0) rnd_port(1); else bus.req1_valid = 0;
         end
         bus.resp_ready = ($urandom_range(0, 3) != 0);
      end
      step();
      reset = 1'b0;
      bus.req0_valid = 0;
      bus.req1_valid = 0;
      bus.resp_ready = 1;
      repeat (4) step();

`ifdef ALU_ARB_STATS_EN
      stats_clr = 1;
      step(); stats_clr = 0;
      for (int k = 0; k < 4; k++) begin
         drive(k == 3, 3'd3, 8'(k), 8'h01);
         step();
         bus.req0_valid = 0;
         bus.req1_valid = 0;
         step();
         step();
      end
      @(negedge clk); chk("stats_counts", {gc0, gc1}, {16'd3, 16'd1});
      step();
      drive(0, 3'd3, 8'h01, 8'h01);
      stats_clr = 1;
      @(negedge clk); chk("stats_clr_hs", bus.req0_ready, 1'b1);
      step(); stats_clr = 0; bus.req0_valid = 0;
      @(negedge clk); chk("stats_cleared", {gc0, gc1}, 32'd0);
      repeat (3) step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
